// File: rtl/demux1to4_8bit_reg.sv
// Registered 1-to-4 byte demultiplexer with per-channel one-entry output registers.
// Optional per-channel accept counters when DEMUX1TO4_COUNT_EN is defined.
module demux1to4_8bit_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
`ifdef DEMUX1TO4_COUNT_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2,
    output logic [15:0]      cnt3
`endif
);

    logic             accept;
    logic [3:0]       load;
    logic [3:0]       consume;
    logic [WIDTH-1:0] data_q [4];

    // Only the addressed channel gates the producer; out_ready feeds through for full rate.
    assign in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid & out_ready;

    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load[in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            out_valid <= load | (out_valid & ~consume);
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    assign out0_data = data_q[0];
    assign out1_data = data_q[1];
    assign out2_data = data_q[2];
    assign out3_data = data_q[3];

`ifdef DEMUX1TO4_COUNT_EN
    logic [15:0] cnt_q [4];

    // Saturating: a counter parked at all-ones means "at least 65535 transfers".
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k] && (cnt_q[k] != 16'hFFFF)) begin
                    cnt_q[k] <= cnt_q[k] + 16'h0001;
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1to4_8bit_reg.sv
// Self-checking bench for demux1to4_8bit_reg against a queue-based channel model.
// Counter checks are compiled in when DEMUX1TO4_COUNT_EN is defined.
module tb_demux1to4_8bit_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data, out1_data, out2_data, out3_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] outs [4];
`ifdef DEMUX1TO4_COUNT_EN
    logic [15:0] cnt0, cnt1, cnt2, cnt3;
    logic [15:0] cnts [4];
    assign cnts[0] = cnt0;
    assign cnts[1] = cnt1;
    assign cnts[2] = cnt2;
    assign cnts[3] = cnt3;
`endif

    assign outs[0] = out0_data;
    assign outs[1] = out1_data;
    assign outs[2] = out2_data;
    assign outs[3] = out3_data;

    always #5 clk = ~clk;

    demux1to4_8bit_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX1TO4_COUNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Each channel is a queue holding at most one byte; data registers remember the last byte loaded.
    logic [7:0]  mq [4][$];
    logic [7:0]  mlast [4];
    int unsigned mcnt [4];
    logic        exp_rdy;
    logic        seen_rdy;

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (mq[k].size() != 0);
        return v;
    endfunction

    // Drives one cycle, samples in_ready before the edge, advances the model, lands 1ns after the edge.
    task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] ordy);
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        exp_rdy = !r && ((mq[s].size() == 0) || ordy[s]);
        #1;
        seen_rdy = in_ready;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete(); mlast[k] = 8'h00; mcnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++)
                if (mq[k].size() != 0 && ordy[k]) void'(mq[k].pop_front());
            if (v && exp_rdy) begin
                mq[s].push_back(d);
                mlast[s] = d;
                if (mcnt[s] < 32'd65535) mcnt[s]++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 2'(i), 8'hFF, 4'b1111);
            n_vec++;
            if (seen_rdy !== 1'b0) begin
                n_err++; $display("FAIL reset_in_ready got %b want 0", seen_rdy);
            end
            n_vec++;
            if (out_valid !== 4'b0000) begin
                n_err++; $display("FAIL reset_out_valid got %b want 0000", out_valid);
            end
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (outs[k] !== 8'h00) begin
                    n_err++; $display("FAIL reset_data%0d got %h want 00", k, outs[k]);
                end
            end
        end
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
        n_vec++;
        if (seen_rdy !== 1'b1) begin
            n_err++; $display("FAIL release_in_ready got %b want 1", seen_rdy);
        end
    endtask

    task automatic test_single_routing();
        cycle(1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000);
        n_vec++;
        if (out_valid !== 4'b0100 || out2_data !== 8'hA5) begin
            n_err++; $display("FAIL route_first got v=%b d=%h want v=0100 d=a5", out_valid, out2_data);
        end
        cycle(1'b0, 1'b1, 2'd2, 8'h3C, 4'b0000);
        n_vec++;
        if (seen_rdy !== 1'b0) begin
            n_err++; $display("FAIL route_stall_ready got %b want 0", seen_rdy);
        end
        n_vec++;
        if (out_valid !== 4'b0100 || out2_data !== 8'hA5) begin
            n_err++; $display("FAIL route_stall_hold got v=%b d=%h want v=0100 d=a5", out_valid, out2_data);
        end
        cycle(1'b0, 1'b1, 2'd2, 8'h3C, 4'b0100);
        n_vec++;
        if (seen_rdy !== 1'b1) begin
            n_err++; $display("FAIL route_passthru_ready got %b want 1", seen_rdy);
        end
        n_vec++;
        if (out_valid !== 4'b0100 || out2_data !== 8'h3C) begin
            n_err++; $display("FAIL route_replace got v=%b d=%h want v=0100 d=3c", out_valid, out2_data);
        end
    endtask

    task automatic test_isolation();
        cycle(1'b0, 1'b1, 2'd1, 8'h5A, 4'b0100);
        cycle(1'b0, 1'b1, 2'd0, 8'h11, 4'b0000);
        n_vec++;
        if (seen_rdy !== 1'b1) begin
            n_err++; $display("FAIL iso_ready_ch0 got %b want 1", seen_rdy);
        end
        cycle(1'b0, 1'b1, 2'd3, 8'h22, 4'b0000);
        n_vec++;
        if (seen_rdy !== 1'b1) begin
            n_err++; $display("FAIL iso_ready_ch3 got %b want 1", seen_rdy);
        end
        n_vec++;
        if (out_valid !== 4'b1011) begin
            n_err++; $display("FAIL iso_valid got %b want 1011", out_valid);
        end
        n_vec++;
        if (out0_data !== 8'h11 || out1_data !== 8'h5A || out3_data !== 8'h22) begin
            n_err++; $display("FAIL iso_data got %h %h %h want 11 5a 22", out0_data, out1_data, out3_data);
        end
    endtask

    task automatic test_throughput();
        logic [7:0] seen [4][$];
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 2'(i % 4), 8'(i), 4'b1111);
            n_vec++;
            if (seen_rdy !== 1'b1) begin
                n_err++; $display("FAIL tput_ready i=%0d got %b want 1", i, seen_rdy);
            end
            if (out_valid[i % 4]) seen[i % 4].push_back(outs[i % 4]);
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (seen[k].size() != 4) begin
                n_err++; $display("FAIL tput_count ch%0d got %0d want 4", k, seen[k].size());
            end else begin
                for (int j = 0; j < 4; j++) begin
                    n_vec++;
                    if (seen[k][j] !== 8'(k + 4 * j)) begin
                        n_err++; $display("FAIL tput_order ch%0d #%0d got %h want %h", k, j, seen[k][j], 8'(k + 4 * j));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 2'(k), 8'(8'hC0 + k), 4'b0000);
        n_vec++;
        if (out_valid !== 4'b1111) begin
            n_err++; $display("FAIL mid_fill got %b want 1111", out_valid);
        end
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
        n_vec++;
        if (out_valid !== 4'b0000 || {out0_data, out1_data, out2_data, out3_data} !== 32'h0) begin
            n_err++; $display("FAIL mid_reset got v=%b d=%h%h%h%h want 0000/0", out_valid, out0_data, out1_data, out2_data, out3_data);
        end
        cycle(1'b0, 1'b1, 2'd0, 8'h77, 4'b0000);
        n_vec++;
        if (out_valid !== 4'b0001 || out0_data !== 8'h77) begin
            n_err++; $display("FAIL mid_first got v=%b d=%h want 0001 77", out_valid, out0_data);
        end
    endtask

    task automatic test_random();
        logic       v, r;
        logic [1:0] s;
        logic [7:0] d;
        logic       pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            if (!pending) begin
                v = $urandom_range(0, 3) != 0;
                s = 2'($urandom_range(0, 3));
                d = 8'($urandom);
            end
            cycle(r, v, s, d, 4'($urandom));
            pending = v && !exp_rdy && !r;
            n_vec++;
            if (seen_rdy !== exp_rdy) begin
                n_err++; $display("FAIL rand_ready i=%0d got %b want %b", i, seen_rdy, exp_rdy);
            end
            n_vec++;
            if (out_valid !== exp_valid()) begin
                n_err++; $display("FAIL rand_valid i=%0d got %b want %b", i, out_valid, exp_valid());
            end
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (outs[k] !== mlast[k]) begin
                    n_err++; $display("FAIL rand_data%0d i=%0d got %h want %h", k, i, outs[k], mlast[k]);
                end
`ifdef DEMUX1TO4_COUNT_EN
                n_vec++;
                if (cnts[k] !== 16'(mcnt[k])) begin
                    n_err++; $display("FAIL rand_cnt%0d i=%0d got %0d want %0d", k, i, cnts[k], mcnt[k]);
                end
`endif
            end
        end
    endtask

`ifdef DEMUX1TO4_COUNT_EN
    task automatic test_counters();
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'd0, 8'(i), 4'b1111);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'd3, 8'(i), 4'b1111);
        n_vec++;
        if (cnt0 !== 16'd5 || cnt1 !== 16'd0 || cnt2 !== 16'd0 || cnt3 !== 16'd3) begin
            n_err++; $display("FAIL cnt_basic got %0d %0d %0d %0d want 5 0 0 3", cnt0, cnt1, cnt2, cnt3);
        end
        for (int i = 0; i < 65534; i++) cycle(1'b0, 1'b1, 2'd1, 8'h01, 4'b1111);
        n_vec++;
        if (cnt1 !== 16'hFFFE) begin
            n_err++; $display("FAIL cnt_preload got %h want fffe", cnt1);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 2'd1, 8'h02, 4'b1111);
        n_vec++;
        if (cnt1 !== 16'hFFFF) begin
            n_err++; $display("FAIL cnt_saturate got %h want ffff", cnt1);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            mlast[k] = 8'h00; mcnt[k] = 0;
        end
        test_reset();
        test_single_routing();
        test_isolation();
        test_throughput();
        test_reset_mid();
        test_random();
`ifdef DEMUX1TO4_COUNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
